and_gate_bist_ctrl: RTL and testbench
=====================================

AND_GATE_BIST_CTRL -- requirements
Module: and_gate_bist_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RST.
REQ-002 Parameter SETTLE SHALL default to 2, range 1..15, and set the number of cycles each vector is driven before its outputs are sampled.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 START  input  1  run request, sampled on CLK.
REQ-006 ABORT  input  1  synchronous run cancel.
REQ-007 A1, B1, A2, B2  output  1 each  stimulus to the dual 2-input AND gate under test.
REQ-008 Y1, Y2  input  1 each  gate outputs returned from the gate under test.
REQ-009 BUSY  output  1  run in progress.
REQ-010 DONE  output  1  run complete; level held until the next run starts, ABORT or RST.
REQ-011 PASS  output  1  equals DONE and FAIL_MAP==0.
REQ-012 FAIL_MAP  output  8  one bit per vector; 1 = mismatch.
REQ-013 ERR_CNT  output  4  number of failing vectors (0..8).

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, CHECK, FIN.
REQ-015 The vector table SHALL be as follows, listed as index: gate (A,B):
- 0..3: gate 1 = (1,1), (0,1), (1,0), (0,0).
- 4..7: gate 2 = (1,1), (0,1), (1,0), (0,0).
REQ-016 While a vector is driven, the inputs of the gate not under test SHALL be 0.
REQ-017 For each vector, expected Y of the gate under test = A AND B, and expected Y of the other gate = 0.
REQ-018 A vector SHALL fail if either Y1 or Y2 differs from its expected value.
REQ-019 IDLE to WAIT: START=1 at edge E0 SHALL set idx=0, drive vector 0, cnt=SETTLE, BUSY=1, DONE=0, FAIL_MAP=0, ERR_CNT=0.
REQ-020 WAIT: cnt SHALL decrement each edge; when cnt==1 the next state SHALL be CHECK, so WAIT lasts exactly SETTLE cycles.
REQ-021 CHECK (one cycle): on its edge the block SHALL sample Y1/Y2 and set FAIL_MAP[idx] and increment ERR_CNT on mismatch.
- If idx<7: idx+1, drive the next vector, reload cnt=SETTLE, go to WAIT.
- If idx==7: go to FIN.
REQ-022 Vector i SHALL be driven starting at edge E0+i*(SETTLE+1) and sampled at edge E0+i*(SETTLE+1)+SETTLE+1.
REQ-023 FIN: BUSY=0, DONE=1, A/B all 0; DONE SHALL assert after edge E0+8*(SETTLE+1), i.e. 24 cycles for SETTLE=2.
REQ-024 START SHALL be ignored in WAIT and CHECK.
REQ-025 START in FIN SHALL behave as from IDLE: clear the results and begin vector 0 on the same edge.
REQ-026 ABORT=1 in any state SHALL, on the next edge, go to IDLE with A/B=0, BUSY=0, DONE=0, FAIL_MAP=0, ERR_CNT=0.
REQ-027 ABORT SHALL have priority over START on the same edge.
REQ-028 ERR_CNT SHALL not wrap; its maximum is 8.
REQ-029 FAIL_MAP and ERR_CNT SHALL be stable, not updating, outside CHECK edges.

Reset
REQ-030 RST=1 SHALL asynchronously force IDLE, idx=0, cnt=0, A1=B1=A2=B2=0, BUSY=0, DONE=0, PASS=0, FAIL_MAP=0, ERR_CNT=0, regardless of CLK.
REQ-031 Reset mid-run SHALL discard all partial results.
REQ-032 The first START after RST is released SHALL start a clean run.

Verification
REQ-033 Good gate, SETTLE=2, 1-cycle START: A1B1 sequence 11,01,10,00 then A2B2 sequence 11,01,10,00, each held 3 cycles -> DONE=1 at cycle 24, PASS=1, FAIL_MAP=8'h00, ERR_CNT=0.
REQ-034 Y1 stuck-at-0 -> FAIL_MAP=8'h01, ERR_CNT=1, PASS=0.
REQ-035 Y1 stuck-at-1 -> FAIL_MAP=8'hFE, ERR_CNT=7.
REQ-036 Y2 stuck-at-1 -> FAIL_MAP=8'hEF, ERR_CNT=7.
REQ-037 START pulsed during vector 2, then ABORT during vector 5 -> run unaffected by START; IDLE one edge after ABORT with all outputs 0; a new START gives a clean 24-cycle run.
REQ-038 RST asserted between edges during vector 3 -> all outputs 0 immediately without a clock edge; START from FIN with a good gate after a failing run -> FAIL_MAP cleared at the START edge and PASS=1 at completion.

Source files
------------

// File: rtl/and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : and_gate_bist_ctrl
// Purpose  : Built-in self test sequencer for a dual 2-input AND gate. It
//            applies an 8-vector table and records a per-vector fail map.
// Revision : 1.0 - initial release
// ============================================================================

module and_gate_bist_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    output logic       A1,
    output logic       B1,
    output logic       A2,
    output logic       B2,
    input  logic       Y1,
    input  logic       Y2,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] FAIL_MAP,
    output logic [3:0] ERR_CNT
);

    localparam logic [3:0] c_settle  = 4'(SETTLE);
    localparam logic [3:0] c_err_max = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [3:0] r_vec;       // {A1, B1, A2, B2}
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_fail_map;
    logic [3:0] r_err_cnt;

    state_t     w_state_nxt;
    logic [2:0] w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_vec_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic [7:0] w_fail_map_nxt;
    logic [3:0] w_err_cnt_nxt;
    logic       w_mismatch;

    // Index bit 2 selects the gate; bits 1:0 walk (1,1),(0,1),(1,0),(0,0).
    // The idle gate always sees zeros so its expected output is 0.
    function automatic logic [3:0] vec_for(input logic [2:0] idx);
        logic [1:0] ab;
        ab = {~idx[0], ~idx[1]};
        return idx[2] ? {2'b00, ab} : {ab, 2'b00};
    endfunction

    assign w_mismatch = (Y1 != (r_vec[3] & r_vec[2])) ||
                        (Y2 != (r_vec[1] & r_vec[0]));

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_vec_nxt      = r_vec;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_fail_map_nxt = r_fail_map;
        w_err_cnt_nxt  = r_err_cnt;

        if (ABORT) begin
            w_state_nxt    = IDLE;
            w_idx_nxt      = 3'd0;
            w_cnt_nxt      = 4'd0;
            w_vec_nxt      = 4'b0000;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b0;
            w_fail_map_nxt = 8'h00;
            w_err_cnt_nxt  = 4'd0;
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    if (START) begin
                        w_state_nxt    = WAIT;
                        w_idx_nxt      = 3'd0;
                        w_cnt_nxt      = c_settle;
                        w_vec_nxt      = vec_for(3'd0);
                        w_busy_nxt     = 1'b1;
                        w_done_nxt     = 1'b0;
                        w_fail_map_nxt = 8'h00;
                        w_err_cnt_nxt  = 4'd0;
                    end
                end
                WAIT: begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        w_fail_map_nxt[r_idx] = 1'b1;
                        if (r_err_cnt != c_err_max) begin
                            w_err_cnt_nxt = r_err_cnt + 4'd1;
                        end
                    end
                    if (r_idx != 3'd7) begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_vec_nxt   = vec_for(r_idx + 3'd1);
                        w_cnt_nxt   = c_settle;
                        w_state_nxt = WAIT;
                    end else begin
                        w_vec_nxt   = 4'b0000;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = FIN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= 4'd0;
            r_vec      <= 4'b0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail_map <= 8'h00;
            r_err_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_vec      <= w_vec_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_fail_map <= w_fail_map_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign A1       = r_vec[3];
    assign B1       = r_vec[2];
    assign A2       = r_vec[1];
    assign B2       = r_vec[0];
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_done && (r_fail_map == 8'h00);
    assign FAIL_MAP = r_fail_map;
    assign ERR_CNT  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_and_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_and_gate_bist_ctrl
// Purpose  : Self-checking bench for and_gate_bist_ctrl with a fault-injectable
//            gate model and an edge-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_and_gate_bist_ctrl;

    localparam int S  = 2;
    localparam int VP = S + 1;   // cycles per vector

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic       A1, B1, A2, B2;
    logic       Y1, Y2;
    logic       BUSY, DONE, PASS;
    logic [7:0] FAIL_MAP;
    logic [3:0] ERR_CNT;

    // 0 good, 1 Y1 stuck-0, 2 Y1 stuck-1, 3 Y2 stuck-1, 4 Y1 inverted
    int fault = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // {A1,B1,A2,B2} for each vector index
    logic [3:0] vec_tab [8] = '{4'b1100, 4'b0100, 4'b1000, 4'b0000,
                                4'b0011, 4'b0001, 4'b0010, 4'b0000};

    and_gate_bist_ctrl #(.SETTLE(S)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .A1(A1), .B1(B1), .A2(A2), .B2(B2),
        .Y1(Y1), .Y2(Y2),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .FAIL_MAP(FAIL_MAP), .ERR_CNT(ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic gate_y1(input logic a, input logic b);
        case (fault)
            1:       return 1'b0;
            2:       return 1'b1;
            4:       return ~(a & b);
            default: return a & b;
        endcase
    endfunction

    function automatic logic gate_y2(input logic a, input logic b);
        return (fault == 3) ? 1'b1 : (a & b);
    endfunction

    assign Y1 = gate_y1(A1, B1);
    assign Y2 = gate_y2(A2, B2);

    function automatic bit vec_fails(input int i);
        logic [3:0] v;
        v = vec_tab[i];
        return (gate_y1(v[3], v[2]) != (v[3] & v[2])) ||
               (gate_y2(v[1], v[0]) != (v[1] & v[0]));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a count k of edges since the START edge.
    bit         m_run  = 1'b0;
    int         m_k    = 0;
    bit         m_done = 1'b0;
    logic [7:0] m_fail = 8'h00;
    int         m_err  = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_run <= 1'b0; m_k <= 0; m_done <= 1'b0; m_fail <= 8'h00; m_err <= 0;
        end else if (ABORT) begin
            m_run <= 1'b0; m_k <= 0; m_done <= 1'b0; m_fail <= 8'h00; m_err <= 0;
        end else if (!m_run) begin
            if (START) begin
                m_run <= 1'b1; m_k <= 0; m_done <= 1'b0; m_fail <= 8'h00; m_err <= 0;
            end
        end else begin
            m_k <= m_k + 1;
            if ((m_k + 1) % VP == 0) begin
                if (vec_fails(m_k / VP)) begin
                    m_fail[m_k / VP] <= 1'b1;
                    m_err <= m_err + 1;
                end
                if (m_k + 1 == 8 * VP) begin
                    m_run  <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("cyc_vec",  {A1, B1, A2, B2}, m_run ? vec_tab[m_k / VP] : 4'b0000);
        chk("cyc_busy", BUSY, m_run);
        chk("cyc_done", DONE, m_done);
        chk("cyc_pass", PASS, m_done && (m_fail == 8'h00));
        chk("cyc_fmap", FAIL_MAP, m_fail);
        chk("cyc_ecnt", ERR_CNT, m_err);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step(1);
        START = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!DONE && c < 60) begin
            step(1);
            c++;
        end
        if (!DONE) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {A1, B1, A2, B2, BUSY, DONE, PASS, FAIL_MAP, ERR_CNT}, 0);
    endtask

    task automatic fault_run(input int f, input string name, input int exp_map, input int exp_err);
        int c;
        fault = f;
        pulse_start();
        wait_done(0, c);
        chk({name, "_lat"},  c, 24);
        chk({name, "_map"},  FAIL_MAP, exp_map);
        chk({name, "_err"},  ERR_CNT, exp_err);
        chk({name, "_pass"}, PASS, (exp_map == 0) ? 1 : 0);
    endtask

    initial begin
        int c;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        step(3);
        chk_all_zero("reset_state");
        RST = 1'b0;
        step(2);

        // Good gate, full vector walk
        pulse_start();
        chk("good_vec0", {A1, B1, A2, B2}, 4'b1100);
        chk("good_busy", BUSY, 1);
        step(3);
        chk("good_vec1", {A1, B1, A2, B2}, 4'b0100);
        wait_done(3, c);
        chk("good_lat", c, 24);
        chk("good_pass", PASS, 1);
        chk("good_map", FAIL_MAP, 8'h00);
        chk("good_err", ERR_CNT, 0);

        fault_run(1, "y1_sa0", 8'h01, 1);
        fault_run(2, "y1_sa1", 8'hFE, 7);
        fault_run(3, "y2_sa1", 8'hEF, 7);
        fault_run(4, "y1_inv", 8'hFF, 8);

        // START ignored mid-run, then ABORT
        fault = 0;
        pulse_start();
        step(7);
        pulse_start();
        step(4);
        chk("ign_start_vec4", {A1, B1, A2, B2}, 4'b0011);
        step(4);
        ABORT = 1'b1;
        step(1);
        ABORT = 1'b0;
        chk_all_zero("abort_idle");
        step(3);
        chk("abort_stays", BUSY, 0);
        fault_run(0, "post_abort", 8'h00, 0);

        // Asynchronous reset mid-run, between edges
        fault = 2;
        pulse_start();
        step(10);
        chk("partial_map", FAIL_MAP, 8'h06);
        #2 RST = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step(2);
        RST = 1'b0;
        step(2);
        fault_run(2, "post_rst", 8'hFE, 7);

        // Restart from FIN with a good gate
        fault = 0;
        pulse_start();
        chk("fin_restart_map", FAIL_MAP, 8'h00);
        chk("fin_restart_err", ERR_CNT, 0);
        chk("fin_restart_flags", {BUSY, DONE}, 2'b10);
        wait_done(0, c);
        chk("fin_restart_lat", c, 24);
        chk("fin_restart_pass", PASS, 1);

        // ABORT wins over START from FIN
        START = 1'b1; ABORT = 1'b1;
        step(1);
        START = 1'b0; ABORT = 1'b0;
        chk_all_zero("abort_prio");
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
